// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control block: forwarding select encodings
// and the default register geometry.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF    = 5;
    localparam int ALU_OP_W_DEF = 4;
    localparam int LINK_REG     = 31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/pipe_ctrl_fwd_select.sv
// Single-operand forwarding compare: picks EX/MEM, MEM/WB or the register file
// for one EX source register.
module pipe_ctrl_fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             mem_we_i,
    input  logic             mem_m2r_i,
    input  logic [REG_W-1:0] mem_wr_i,
    input  logic             wb_we_i,
    input  logic [REG_W-1:0] wb_wr_i,
    output logic [1:0]       sel_o
);

    logic src_live;
    assign src_live = (src_i != '0);

    // A load in EX/MEM has no data yet, so it is never a forward source there.
    always_comb begin
        sel_o = FWD_RF;
        if (src_live && mem_we_i && !mem_m2r_i && (mem_wr_i == src_i))
            sel_o = FWD_MEM;
        else if (src_live && wb_we_i && (wb_wr_i == src_i))
            sel_o = FWD_WB;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: carries decoded control through ID/EX, EX/MEM and MEM/WB,
// resolves destinations, inserts load-use bubbles, flushes on redirect, forwards.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int ALU_OP_W = ALU_OP_W_DEF,
    parameter int LINK_REG_P = LINK_REG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic                id_reg_write,
    input  logic                id_mem_to_reg,
    input  logic                id_mem_write,
    input  logic                id_alu_src,
    input  logic                id_reg_dest,
    input  logic                id_branch,
    input  logic                id_jump,
    input  logic                id_jump_reg,
    input  logic                id_jump_link,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                ex_redirect,
    output logic                stall_fd,
    output logic                flush_fd,
    output logic                ex_reg_write,
    output logic                ex_mem_to_reg,
    output logic                ex_mem_write,
    output logic                ex_alu_src,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic                ex_jump_reg,
    output logic                ex_jump_link,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [REG_W-1:0]    ex_rs,
    output logic [REG_W-1:0]    ex_rt,
    output logic [REG_W-1:0]    ex_write_reg,
    output logic                mem_reg_write,
    output logic                mem_mem_to_reg,
    output logic                mem_mem_write,
    output logic [REG_W-1:0]    mem_write_reg,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [REG_W-1:0]    wb_write_reg,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b
);

    // ID/EX
    logic                ex_rw_q, ex_m2r_q, ex_mw_q, ex_as_q;
    logic                ex_br_q, ex_j_q, ex_jr_q, ex_jl_q;
    logic [ALU_OP_W-1:0] ex_op_q;
    logic [REG_W-1:0]    ex_rs_q, ex_rt_q, ex_wr_q;
    logic                ex_rw_d, ex_m2r_d, ex_mw_d, ex_as_d;
    logic                ex_br_d, ex_j_d, ex_jr_d, ex_jl_d;
    logic [ALU_OP_W-1:0] ex_op_d;
    logic [REG_W-1:0]    ex_rs_d, ex_rt_d, ex_wr_d;
    // EX/MEM
    logic                mem_rw_q, mem_m2r_q, mem_mw_q;
    logic [REG_W-1:0]    mem_wr_q;
    // MEM/WB
    logic                wb_rw_q, wb_m2r_q;
    logic [REG_W-1:0]    wb_wr_q;

    logic [REG_W-1:0]    id_dest;
    logic                load_use;
    logic                bubble;
    logic                mem_we_gated, wb_we_gated;

    always_comb begin
        id_dest = id_rt;
        if (id_jump_link)
            id_dest = REG_W'(LINK_REG_P);
        else if (id_reg_dest)
            id_dest = id_rd;
    end

    assign load_use = ex_m2r_q && ex_rw_q && (ex_wr_q != '0) && id_valid &&
                      ((ex_wr_q == id_rs) || (ex_wr_q == id_rt));

    // Reset dominates everything; redirect discards the younger instruction
    // so a coincident load-use must not also stall.
    assign flush_fd = !reset && ex_redirect;
    assign stall_fd = !reset && !ex_redirect && load_use;
    assign bubble   = ex_redirect || load_use || !id_valid;

    always_comb begin
        ex_rw_d  = 1'b0;
        ex_m2r_d = 1'b0;
        ex_mw_d  = 1'b0;
        ex_as_d  = 1'b0;
        ex_br_d  = 1'b0;
        ex_j_d   = 1'b0;
        ex_jr_d  = 1'b0;
        ex_jl_d  = 1'b0;
        ex_op_d  = '0;
        ex_rs_d  = '0;
        ex_rt_d  = '0;
        ex_wr_d  = '0;
        if (!bubble) begin
            ex_rw_d  = id_reg_write;
            ex_m2r_d = id_mem_to_reg;
            ex_mw_d  = id_mem_write;
            ex_as_d  = id_alu_src;
            ex_br_d  = id_branch;
            ex_j_d   = id_jump;
            ex_jr_d  = id_jump_reg;
            ex_jl_d  = id_jump_link;
            ex_op_d  = id_alu_op;
            ex_rs_d  = id_rs;
            ex_rt_d  = id_rt;
            ex_wr_d  = id_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rw_q   <= 1'b0;
            ex_m2r_q  <= 1'b0;
            ex_mw_q   <= 1'b0;
            ex_as_q   <= 1'b0;
            ex_br_q   <= 1'b0;
            ex_j_q    <= 1'b0;
            ex_jr_q   <= 1'b0;
            ex_jl_q   <= 1'b0;
            ex_op_q   <= '0;
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
            ex_wr_q   <= '0;
            mem_rw_q  <= 1'b0;
            mem_m2r_q <= 1'b0;
            mem_mw_q  <= 1'b0;
            mem_wr_q  <= '0;
            wb_rw_q   <= 1'b0;
            wb_m2r_q  <= 1'b0;
            wb_wr_q   <= '0;
        end else begin
            ex_rw_q   <= ex_rw_d;
            ex_m2r_q  <= ex_m2r_d;
            ex_mw_q   <= ex_mw_d;
            ex_as_q   <= ex_as_d;
            ex_br_q   <= ex_br_d;
            ex_j_q    <= ex_j_d;
            ex_jr_q   <= ex_jr_d;
            ex_jl_q   <= ex_jl_d;
            ex_op_q   <= ex_op_d;
            ex_rs_q   <= ex_rs_d;
            ex_rt_q   <= ex_rt_d;
            ex_wr_q   <= ex_wr_d;
            // Downstream stages never back-pressure.
            mem_rw_q  <= ex_rw_q;
            mem_m2r_q <= ex_m2r_q;
            mem_mw_q  <= ex_mw_q;
            mem_wr_q  <= ex_wr_q;
            wb_rw_q   <= mem_rw_q;
            wb_m2r_q  <= mem_m2r_q;
            wb_wr_q   <= mem_wr_q;
        end
    end

    assign ex_reg_write   = ex_rw_q;
    assign ex_mem_to_reg  = ex_m2r_q;
    assign ex_mem_write   = ex_mw_q;
    assign ex_alu_src     = ex_as_q;
    assign ex_branch      = ex_br_q;
    assign ex_jump        = ex_j_q;
    assign ex_jump_reg    = ex_jr_q;
    assign ex_jump_link   = ex_jl_q;
    assign ex_alu_op      = ex_op_q;
    assign ex_rs          = ex_rs_q;
    assign ex_rt          = ex_rt_q;
    assign ex_write_reg   = ex_wr_q;
    assign mem_reg_write  = mem_rw_q;
    assign mem_mem_to_reg = mem_m2r_q;
    assign mem_mem_write  = mem_mw_q;
    assign mem_write_reg  = mem_wr_q;
    assign wb_reg_write   = wb_rw_q;
    assign wb_mem_to_reg  = wb_m2r_q;
    assign wb_write_reg   = wb_wr_q;

    // Writes to r0 are architecturally dead, so hide them from forwarding.
    assign mem_we_gated = mem_rw_q && (mem_wr_q != '0);
    assign wb_we_gated  = wb_rw_q && (wb_wr_q != '0);

    pipe_ctrl_fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .src_i     (ex_rs_q),
        .mem_we_i  (mem_we_gated),
        .mem_m2r_i (mem_m2r_q),
        .mem_wr_i  (mem_wr_q),
        .wb_we_i   (wb_we_gated),
        .wb_wr_i   (wb_wr_q),
        .sel_o     (fwd_a)
    );

    pipe_ctrl_fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .src_i     (ex_rt_q),
        .mem_we_i  (mem_we_gated),
        .mem_m2r_i (mem_m2r_q),
        .mem_wr_i  (mem_wr_q),
        .wb_we_i   (wb_we_gated),
        .wb_wr_i   (wb_wr_q),
        .sel_o     (fwd_b)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, all checked
// against an instruction-level model of the three downstream stages.
module tb_pipe_ctrl;

    typedef struct packed {
        logic       rw, m2r, mw, as, rdst, br, j, jr, jl;
        logic [3:0] op;
        logic [4:0] rs, rt, rd, wr;
    } ins_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_to_reg = 1'b0, id_mem_write = 1'b0;
    logic       id_alu_src = 1'b0, id_reg_dest = 1'b0, id_branch = 1'b0;
    logic       id_jump = 1'b0, id_jump_reg = 1'b0, id_jump_link = 1'b0;
    logic [3:0] id_alu_op = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_redirect = 1'b0;
    logic       stall_fd, flush_fd;
    logic       ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src;
    logic       ex_branch, ex_jump, ex_jump_reg, ex_jump_link;
    logic [3:0] ex_alu_op;
    logic [4:0] ex_rs, ex_rt, ex_write_reg;
    logic       mem_reg_write, mem_mem_to_reg, mem_mem_write;
    logic [4:0] mem_write_reg;
    logic       wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_write_reg;
    logic [1:0] fwd_a, fwd_b;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_reg_dest(id_reg_dest), .id_branch(id_branch), .id_jump(id_jump),
        .id_jump_reg(id_jump_reg), .id_jump_link(id_jump_link),
        .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .stall_fd(stall_fd), .flush_fd(flush_fd),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jump_reg(ex_jump_reg),
        .ex_jump_link(ex_jump_link), .ex_alu_op(ex_alu_op), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_mem_write(mem_mem_write), .mem_write_reg(mem_write_reg),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_write_reg(wb_write_reg), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    ins_t pipe[$];          // [0]=in EX, [1]=in MEM, [2]=in WB
    ins_t l_b = '0;
    bit   l_v = 0, l_redir = 0, l_rst = 1;
    bit   exp_stall = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] dest_of(ins_t b);
        if (b.jl) return 5'd31;
        if (b.rdst) return b.rd;
        return b.rt;
    endfunction

    function automatic bit hazard(ins_t b, bit v);
        ins_t e = pipe[0];
        return e.m2r && e.rw && e.wr != 0 && v && (e.wr == b.rs || e.wr == b.rt);
    endfunction

    function automatic logic [1:0] exp_fwd(logic [4:0] src);
        ins_t m = pipe[1];
        ins_t w = pipe[2];
        if (src != 0 && m.rw && !m.m2r && m.wr == src) return 2'b10;
        if (src != 0 && w.rw && w.wr == src) return 2'b01;
        return 2'b00;
    endfunction

    // Move every instruction one stage down according to last cycle's inputs.
    task automatic model_adv();
        ins_t n = '0;
        if (l_rst) begin
            pipe = '{'0, '0, '0};
        end else begin
            if (l_v && !l_redir && !hazard(l_b, l_v)) begin
                n = l_b;
                n.wr = dest_of(l_b);
            end
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
    endtask

    task automatic step(ins_t b, bit v, bit redir, bit rst);
        ins_t e, m, w;
        @(posedge clk);
        model_adv();
        #1;
        reset = rst; id_valid = v; ex_redirect = redir;
        id_reg_write = b.rw; id_mem_to_reg = b.m2r; id_mem_write = b.mw;
        id_alu_src = b.as; id_reg_dest = b.rdst; id_branch = b.br;
        id_jump = b.j; id_jump_reg = b.jr; id_jump_link = b.jl;
        id_alu_op = b.op; id_rs = b.rs; id_rt = b.rt; id_rd = b.rd;
        l_b = b; l_v = v; l_redir = redir; l_rst = rst;
        #4;
        e = pipe[0]; m = pipe[1]; w = pipe[2];
        exp_stall = !rst && !redir && hazard(b, v);
        chk("stall", stall_fd, exp_stall);
        chk("flush", flush_fd, !rst && redir);
        chk("fwd_a", fwd_a, exp_fwd(e.rs));
        chk("fwd_b", fwd_b, exp_fwd(e.rt));
        chk("ex_ctl", {ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src,
                       ex_branch, ex_jump, ex_jump_reg, ex_jump_link},
            {e.rw, e.m2r, e.mw, e.as, e.br, e.j, e.jr, e.jl});
        chk("ex_fields", {ex_alu_op, ex_rs, ex_rt, ex_write_reg},
            {e.op, e.rs, e.rt, e.wr});
        chk("mem", {mem_reg_write, mem_mem_to_reg, mem_mem_write, mem_write_reg},
            {m.rw, m.m2r, m.mw, m.wr});
        chk("wb", {wb_reg_write, wb_mem_to_reg, wb_write_reg},
            {w.rw, w.m2r, w.wr});
    endtask

    function automatic ins_t mk(bit rw, bit m2r, bit as, bit rdst, bit jl,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        ins_t b = '0;
        b.rw = rw; b.m2r = m2r; b.as = as; b.rdst = rdst; b.jl = jl; b.j = jl;
        b.rs = rs; b.rt = rt; b.rd = rd; b.op = 4'h3;
        return b;
    endfunction

    initial begin
        ins_t nop, ones, addiu, addu, lw, dep, jal, wr0, use0, rb;
        bit   v;
        pipe = '{'0, '0, '0};
        nop   = '0;
        ones  = '1;
        addiu = mk(1, 0, 1, 0, 0, 5'd0, 5'd8, 5'd0);
        addu  = mk(1, 0, 0, 1, 0, 5'd8, 5'd0, 5'd10);
        lw    = mk(1, 1, 1, 0, 0, 5'd0, 5'd9, 5'd0);
        dep   = mk(1, 0, 0, 1, 0, 5'd0, 5'd9, 5'd3);
        jal   = mk(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        wr0   = mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        use0  = mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd4);

        // Reset with every decode input high, then idle after release.
        step(ones, 1, 1, 1);
        step(ones, 1, 1, 1);
        chk("t1_ex_wr", ex_write_reg, 0);
        chk("t1_stall", stall_fd, 0);
        chk("t1_flush", flush_fd, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        chk("t1_idle", {ex_reg_write, mem_reg_write, wb_reg_write, ex_write_reg}, 0);

        // Back-to-back dependency forwards from EX/MEM, one gap from MEM/WB.
        step(addiu, 1, 0, 0);
        step(addu, 1, 0, 0);
        chk("t2_ex_wr", ex_write_reg, 8);
        step(nop, 0, 0, 0);
        chk("t2_fwd_mem", fwd_a, 2'b10);
        step(addiu, 1, 0, 0);
        step(nop, 0, 0, 0);
        step(addu, 1, 0, 0);
        step(nop, 0, 0, 0);
        chk("t2_fwd_wb", fwd_a, 2'b01);

        // Load-use: one stall, one bubble, then forward from MEM/WB.
        step(lw, 1, 0, 0);
        step(dep, 1, 0, 0);
        chk("t3_stall", stall_fd, 1);
        step(dep, 1, 0, 0);
        chk("t3_no_stall", stall_fd, 0);
        chk("t3_bubble", {ex_reg_write, ex_mem_to_reg, ex_write_reg, ex_rt}, 0);
        step(nop, 0, 0, 0);
        chk("t3_fwd_b", fwd_b, 2'b01);
        chk("t3_stall_end", stall_fd, 0);

        // Redirect beats load-use.
        step(lw, 1, 0, 0);
        step(dep, 1, 1, 0);
        chk("t4_flush", flush_fd, 1);
        chk("t4_stall", stall_fd, 0);
        step(nop, 0, 0, 0);
        chk("t4_bubble", {ex_reg_write, ex_rs, ex_rt, ex_write_reg}, 0);

        // Link destination and r0 never forwards.
        step(jal, 1, 0, 0);
        step(nop, 0, 0, 0);
        chk("t5_ex_link", ex_write_reg, 31);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        chk("t5_wb_link", wb_write_reg, 31);
        step(wr0, 1, 0, 0);
        step(use0, 1, 0, 0);
        step(nop, 0, 0, 0);
        chk("t5_r0_fwd", {fwd_a, fwd_b}, 0);

        // Reset during an active stall.
        step(lw, 1, 0, 0);
        step(dep, 1, 0, 1);
        chk("t6_stall_rst", stall_fd, 0);
        step(nop, 0, 0, 0);
        chk("t6_clear", {ex_reg_write, ex_mem_to_reg, ex_write_reg,
                         mem_reg_write, wb_reg_write, stall_fd}, 0);

        // Random traffic on a small register set so hazards are frequent.
        rb = '0;
        v = 0;
        for (int i = 0; i < 600; i++) begin
            if (!exp_stall) begin
                rb = ins_t'({$urandom, $urandom});
                rb.rs = 5'($urandom_range(0, 3));
                rb.rt = 5'($urandom_range(0, 3));
                rb.rd = 5'($urandom_range(0, 3));
                rb.jl = ($urandom % 8) == 0;
                v = ($urandom % 5) != 0;
            end
            step(rb, v, ($urandom % 8) == 0, ($urandom % 60) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Consumes the decode-stage control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Resolves the destination register for each instruction.
- Detects load-use hazards and inserts one bubble for each.
- Generates EX-stage forwarding selects and applies flushes on control-flow redirect.
- Sits between the decode stage and the EX/MEM/WB datapath; the datapath muxes are driven only from this block's outputs.

Parameters:
- REG_W, 5, register-address width.
- ALU_OP_W, 4, ALU-op width.
- LINK_REG, 31, destination register for jump_link.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  decode-stage instruction valid; 0 means the bundle is a bubble.
- id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_dest, id_branch, id_jump, id_jump_reg, id_jump_link  in  1 each  decoded control.
- id_alu_op  in  ALU_OP_W  decoded ALU op.
- id_rs, id_rt, id_rd  in  REG_W each  decoded register fields.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- stall_fd  out  1  hold PC and IF/ID.
- flush_fd  out  1  zero IF/ID.
- ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_branch, ex_jump, ex_jump_reg, ex_jump_link  out  1 each  ID/EX control.
- ex_alu_op  out  ALU_OP_W  ID/EX ALU op.
- ex_rs, ex_rt, ex_write_reg  out  REG_W each  ID/EX register fields.
- mem_reg_write, mem_mem_to_reg, mem_mem_write  out  1 each  EX/MEM control.
- mem_write_reg  out  REG_W  EX/MEM destination.
- wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control.
- wb_write_reg  out  REG_W  MEM/WB destination.
- fwd_a, fwd_b  out  2 each  EX operand source selects.

Behaviour:
- Reset: every registered output is 0; stall_fd=0, flush_fd=0, fwd_a=fwd_b=00.
- Destination select, combinational in ID:
  - id_jump_link → LINK_REG.
  - else id_reg_dest → id_rd.
  - else → id_rt.
  - The result is registered into ex_write_reg.
- Gated write enables: any stage whose write_reg is 0 presents its reg_write to the forwarding logic as 0. The output port itself is unchanged.
- Load-use hazard, combinational:
  - Condition: ex_mem_to_reg & ex_reg_write & ex_write_reg≠0 & id_valid & (ex_write_reg==id_rs | ex_write_reg==id_rt).
  - Response: stall_fd=1 and a bubble is loaded into ID/EX.
- Redirect: ex_redirect=1 → flush_fd=1, bubble into ID/EX, stall_fd=0.
  - Redirect overrides load-use in the same cycle; the younger instruction is discarded.
- Priority, highest first: reset > ex_redirect > load-use > normal advance.
- Bubble: every ID/EX control bit and field is 0. Also loaded when id_valid=0.
- EX/MEM and MEM/WB registers advance every cycle unconditionally; there is no back-pressure from memory.
- Latency: control issued in ID appears on ex_* one cycle later, mem_* two cycles later, wb_* three cycles later.
- Forwarding, combinational, evaluated independently for ex_rs→fwd_a and ex_rt→fwd_b:
  - 10 if mem_reg_write & ~mem_mem_to_reg & mem_write_reg==src & src≠0.
  - else 01 if wb_reg_write & wb_write_reg==src & src≠0.
  - else 00.
  - EX/MEM takes priority over MEM/WB.
- Register 0 is never a hazard or forward source.
- No combinational path from id_* inputs to any ex_*, mem_* or wb_* output.

Decomposition:
- mips.h gains these constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and LINK_REG.
- Natural sub-module: fwd_select, a combinational single-operand forwarding compare, instantiated twice (operands A and B).
- Hazard detection and the pipeline registers stay in pipe_ctrl.

Test Plan:
1. reset held 2 cycles with all id_* inputs = 1 → all outputs 0; release reset with id_valid=0 → outputs stay 0.
2. ADDIU to r8 (reg_write=1, alu_src=1, rt=8) then ADDU reading rs=8 on the next cycle → ex_write_reg=8, then fwd_a=10 on the ADDU's EX cycle; with one NOP between them → fwd_a=01.
3. LW r9 (mem_to_reg=1, rt=9), then an instruction with rt=9 → stall_fd=1 for exactly one cycle and ex_* all 0 for that cycle; next cycle fwd_b=01 and no stall.
4. LW r9 in EX, dependent instruction in ID, and ex_redirect=1 in the same cycle → flush_fd=1, stall_fd=0, ID/EX bubble.
5. JAL (jump_link=1) → ex_write_reg=31, wb_write_reg=31 three cycles after issue; a write targeting rd=0 produces fwd_a=fwd_b=00 for a consumer with rs=0.
6. reset asserted while a load-use stall is active → next cycle all outputs 0, stall_fd=0.
